// File: rtl/jtkicker_objram_arb.sv
// ============================================================================
// Module   : jtkicker_objram_arb
// Brief    : Single-port object RAM sequencer shared by the CPU (obj1/obj2) and
//            the sprite scanner. Round-robin grant, fixed-latency accesses.
//            Optional double buffering with macro JTKICKER_OBJ_DBUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module jtkicker_objram_arb #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic          cpu_cs,
    input  logic          cpu_bank,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_rnw,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ok,
    input  logic          scan_req,
    input  logic [AW:0]   scan_addr,
    output logic [7:0]    scan_data,
    output logic          scan_ok,
    input  logic          LVBL,
    output logic [AW+1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t          state_q;
    logic            served_q;
    logic            last_scan_q;   // 1: scanner got the previous grant
    logic            owner_q;       // 1: access in flight belongs to the scanner
    logic [AW+1:0]   ram_addr_q;
    logic [7:0]      ram_din_q;
    logic            ram_we_q;
    logic [7:0]      cpu_dout_q;
    logic [7:0]      scan_data_q;
    logic            scan_ok_q;

    logic            cpu_pend;
    logic            scan_pend;
    logic            gnt_cpu;
    logic            gnt_scan;
    logic            cpu_buf;
    logic            scan_buf;

    // A scanner request still high in its scan_ok cycle is the old one.
    always_comb begin
        cpu_pend  = cpu_cs & ~served_q;
        scan_pend = scan_req & ~scan_ok_q;
        gnt_cpu   = cpu_pend & (~scan_pend | last_scan_q);
        gnt_scan  = scan_pend & ~gnt_cpu;
    end

`ifdef JTKICKER_OBJ_DBUF_EN
    logic buf_sel_q;
    logic lvbl_q;
    logic tog_pend_q;
    logic lvbl_fall;

    assign lvbl_fall = lvbl_q & ~LVBL;

    // The swap waits for IDLE so an access never straddles both buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_sel_q  <= 1'b0;
            lvbl_q     <= 1'b0;
            tog_pend_q <= 1'b0;
        end else begin
            lvbl_q <= LVBL;
            if (state_q == IDLE && (lvbl_fall || tog_pend_q)) begin
                buf_sel_q  <= ~buf_sel_q;
                tog_pend_q <= 1'b0;
            end else if (lvbl_fall) begin
                tog_pend_q <= 1'b1;
            end
        end
    end

    assign cpu_buf  = ~buf_sel_q;
    assign scan_buf = buf_sel_q;
`else
    logic unused_lvbl;
    assign unused_lvbl = LVBL;
    assign cpu_buf     = 1'b0;
    assign scan_buf    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            served_q    <= 1'b0;
            last_scan_q <= 1'b1;
            owner_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 8'h00;
            ram_we_q    <= 1'b0;
            cpu_dout_q  <= 8'h00;
            scan_data_q <= 8'h00;
            scan_ok_q   <= 1'b0;
        end else begin
            ram_we_q  <= 1'b0;
            scan_ok_q <= 1'b0;
            if (cpu_cen || !cpu_cs) begin
                served_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (gnt_cpu) begin
                        ram_addr_q  <= {cpu_buf, cpu_bank, cpu_addr};
                        last_scan_q <= 1'b0;
                        owner_q     <= 1'b0;
                        if (cpu_rnw) begin
                            state_q <= RD_WAIT;
                        end else begin
                            ram_we_q  <= 1'b1;
                            ram_din_q <= cpu_din;
                            state_q   <= WR;
                        end
                    end else if (gnt_scan) begin
                        ram_addr_q  <= {scan_buf, scan_addr};
                        last_scan_q <= 1'b1;
                        owner_q     <= 1'b1;
                        state_q     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (owner_q) begin
                        scan_data_q <= ram_dout;
                        scan_ok_q   <= 1'b1;
                    end else begin
                        cpu_dout_q <= ram_dout;
                        served_q   <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                WR: begin
                    served_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ok    = served_q & cpu_cs;
    assign cpu_dout  = cpu_dout_q;
    assign scan_data = scan_data_q;
    assign scan_ok   = scan_ok_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;

endmodule

`default_nettype wire
